// File: rtl/prewish5k_controller.sv
// Debounced button loads an active-low DIP mask that is blinked MSB-first on the_led.
// Define PREWISH_STATUS_LEDS_EN to drive o_led0..o_led3 with status; otherwise they stay 0.
module prewish5k_controller #(
  parameter int NEWMASK_CLK_BITS     = 26,
  parameter int BLINKY_MASK_CLK_BITS = 19,
  parameter int DEBOUNCE_CYCLES      = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       button_internal,
  input  logic [7:0] dip_switch,
  output logic       the_led,
  output logic       o_led0,
  output logic       o_led1,
  output logic       o_led2,
  output logic       o_led3
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = NEWMASK_CLK_BITS - 3;
  localparam int BW = BLINKY_MASK_CLK_BITS;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_PRE = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_deb_cnt;
  logic          r_armed;
  logic          r_lock_active;
  logic [LW-1:0] r_lock_cnt;
  logic [BW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [7:0]    r_mask;
  logic          r_led;

  logic [DW-1:0] w_deb_next;
  logic          w_reach;
  logic          w_accept;
  logic          w_wrap;

  // Debounce next value, threshold crossing and acceptance qualification
  always_comb begin
    w_deb_next = '0;
    if (!r_sync2) begin
      w_deb_next = '0;
    end else if (r_deb_cnt == DEB_MAX) begin
      w_deb_next = DEB_MAX;
    end else begin
      w_deb_next = r_deb_cnt + DW'(1);
    end
    w_reach  = r_sync2 && (r_deb_cnt == DEB_PRE);
    w_accept = w_reach && r_armed && !r_lock_active;
    w_wrap   = &r_presc;
  end

  // Button synchronizer, debounce counter and re-arm flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb_cnt <= '0;
      r_armed   <= 1'b1;
    end else begin
      r_sync1   <= button_internal;
      r_sync2   <= r_sync1;
      r_deb_cnt <= w_deb_next;
      if (w_accept) begin
        r_armed <= 1'b0;
      end else if (!r_sync2) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Post-acceptance lockout: active for exactly 2^LW cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_active <= 1'b0;
      r_lock_cnt    <= '0;
    end else if (w_accept) begin
      r_lock_active <= 1'b1;
      r_lock_cnt    <= '0;
    end else if (r_lock_active) begin
      r_lock_active <= ~(&r_lock_cnt);
      r_lock_cnt    <= r_lock_cnt + LW'(1);
    end else begin
      r_lock_active <= 1'b0;
      r_lock_cnt    <= r_lock_cnt;
    end
  end

  // Blink prescaler and step index; acceptance outranks a same-cycle wrap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= 3'd7;
    end else if (w_accept) begin
      r_presc <= '0;
      r_idx   <= 3'd7;
    end else begin
      r_presc <= r_presc + BW'(1);
      if (w_wrap) begin
        r_idx <= r_idx - 3'd1;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // Mask capture and registered blink output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask <= 8'd0;
      r_led  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mask <= ~dip_switch;
      end else begin
        r_mask <= r_mask;
      end
      r_led <= r_mask[r_idx];
    end
  end

  assign the_led = r_led;

`ifdef PREWISH_STATUS_LEDS_EN
  logic r_deb_at;
  logic r_loaded;

  // Status flags: debounced level and mask-loaded-since-reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_deb_at <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_deb_at <= (w_deb_next == DEB_MAX);
      r_loaded <= r_loaded | w_accept;
    end
  end

  assign o_led0 = r_deb_at;
  assign o_led1 = r_lock_active;
  assign o_led2 = r_loaded;
  assign o_led3 = r_presc[BW-1];
`else
  assign o_led0 = 1'b0;
  assign o_led1 = 1'b0;
  assign o_led2 = 1'b0;
  assign o_led3 = 1'b0;
`endif

endmodule

// File: tb/tb_prewish5k_controller.sv
// Directed bench for prewish5k_controller with short lockout (2^13) and 512-cycle blink steps.
module tb_prewish5k_controller;

`ifdef PREWISH_STATUS_LEDS_EN
  localparam bit LEDS_EN = 1'b1;
`else
  localparam bit LEDS_EN = 1'b0;
`endif

  localparam logic [7:0] M1 = 8'b10100000;
  localparam logic [7:0] M2 = 8'b11001100;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [7:0] dip;
  logic       the_led;
  logic       l0, l1, l2, l3;
  logic [3:0] leds;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         e1, e2, r1, t0, rr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign leds = {l3, l2, l1, l0};

  prewish5k_controller #(
    .NEWMASK_CLK_BITS(16),
    .BLINKY_MASK_CLK_BITS(9),
    .DEBOUNCE_CYCLES(32)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .button_internal(btn),
    .dip_switch(dip),
    .the_led(the_led),
    .o_led0(l0),
    .o_led1(l1),
    .o_led2(l2),
    .o_led3(l3)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after rising edge number t
  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sample mid-step s for n steps after an acceptance at edge base
  task automatic chk_pattern(input string tag, input int base, input int s0, input int n,
                             input logic [7:0] m);
    for (int s = s0; s < s0 + n; s++) begin
      step_to(base + 1 + 512 * s + 256);
      check(tag, 8'(the_led), 8'(m[7 - (s % 8)]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    dip = 8'hFF;
    step_to(3);
    check("rst_led", 8'(the_led), 8'd0);
    check("rst_status", 8'(leds), 8'd0);
    step_to(4);
    rst = 1'b0;

    // First press: acceptance lands 34 edges after the button rises
    step_to(10);
    dip = 8'b01011111;
    btn = 1'b1;
    e1 = 10 + 34;
    step_to(e1);
    check("latency_pre", 8'(the_led), 8'd0);
    step_to(e1 + 1);
    check("latency_post", 8'(the_led), 8'd1);
    step_to(10 + 50);
    btn = 1'b0;
    step_to(e1 + 257);
    check("status_p1", 8'(leds), LEDS_EN ? 8'b1110 : 8'd0);
    chk_pattern("pattern_m1", e1, 0, 8, M1);

    // Short press, then a long press inside lockout: both ignored
    step_to(e1 + 3900);
    dip = 8'b00110011;
    btn = 1'b1;
    step_to(e1 + 3910);
    btn = 1'b0;
    chk_pattern("short_press", e1, 8, 2, M1);
    step_to(e1 + 5000);
    btn = 1'b1;
    step_to(e1 + 5100);
    check("lock_status", 8'(leds[1:0]), LEDS_EN ? 8'b11 : 8'd0);
    btn = 1'b0;
    chk_pattern("lock_ignore", e1, 10, 2, M1);

    // After lockout: new mask, index restarts at 7
    step_to(e1 + 8300);
    check("lock_end", 8'(l1), 8'd0);
    r1 = e1 + 8300;
    btn = 1'b1;
    e2 = r1 + 34;
    step_to(r1 + 40);
    btn = 1'b0;
    step_to(e2 + 257);
    check("status_p2", 8'(leds), LEDS_EN ? 8'b1110 : 8'd0);
    chk_pattern("pattern_m2", e2, 0, 8, M2);

    // Hold across lockout end: no second acceptance
    step_to(e2 + 4000);
    dip = 8'hF0;
    btn = 1'b1;
    step_to(e2 + 8192 + 600);
    check("hold_debounced", 8'(l0), 8'(LEDS_EN));
    btn = 1'b0;
    chk_pattern("hold_no_retry", e2, 17, 2, M2);

    // Reset mid-pattern clears outputs and mask
    chk_pattern("pre_reset", e2, 20, 1, M2);
    rst = 1'b1;
    step_to(e2 + 10498);
    check("reset_led", 8'(the_led), 8'd0);
    check("reset_status", 8'(leds), 8'd0);
    rst = 1'b0;
    step_to(e2 + 11100);
    check("mask_cleared", 8'(the_led), 8'd0);
    check("loaded_cleared", 8'(leds[2:1]), 8'd0);

    // Reset mid-debounce: still-held press accepted 34 edges after release
    t0 = cyc;
    dip = 8'b00110011;
    btn = 1'b1;
    step_to(t0 + 20);
    rst = 1'b1;
    step_to(t0 + 21);
    rst = 1'b0;
    rr = t0 + 21;
    step_to(rr + 34);
    check("rst_held_pre", 8'(the_led), 8'd0);
    step_to(rr + 35);
    check("rst_held_post", 8'(the_led), 8'd1);
    step_to(rr + 40);
    btn = 1'b0;
    check("rst_held_loaded", 8'(l2), 8'(LEDS_EN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
